// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that merges functional-unit results onto a single registered CDB port.
// Optional branch-first priority is enabled by defining OOPS_CDB_BRANCH_PRIO_EN.
module cdb_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [N_REQ-1:0]       req_vld_i,
   input  logic [N_REQ*TAG_W-1:0] req_tag_i,
   input  logic [N_REQ*WIDTH-1:0] req_data_i,
   input  logic [N_REQ-1:0]       req_br_i,
   output logic [N_REQ-1:0]       req_rdy_o,
   input  logic                   cdb_rdy_i,
   output logic                   cdb_vld_o,
   output logic [TAG_W-1:0]       cdb_tag_o,
   output logic [WIDTH-1:0]       cdb_data_o,
   output logic [SRC_W-1:0]       cdb_src_o
);

   logic [SRC_W-1:0] r_ptr;
   logic             r_vld;
   logic [TAG_W-1:0] r_tag;
   logic [WIDTH-1:0] r_data;
   logic [SRC_W-1:0] r_src;

   logic             w_allow;
   logic             w_found;
   logic             w_xfer;
   logic [N_REQ-1:0] w_cand;
   logic [N_REQ-1:0] w_grant;
   logic [SRC_W-1:0] w_win;
   logic [SRC_W-1:0] w_ptr_nxt;
   logic [TAG_W-1:0] w_tag;
   logic [WIDTH-1:0] w_data;

   // The output register can take a new word when empty or drained this cycle.
   assign w_allow = (!r_vld || cdb_rdy_i) && !flush && !rst;

`ifdef OOPS_CDB_BRANCH_PRIO_EN
   always_comb begin
      w_cand = req_vld_i;
      if (|(req_vld_i & req_br_i)) w_cand = req_vld_i & req_br_i;
   end
`else
   logic w_unused_br;
   assign w_unused_br = ^req_br_i;
   assign w_cand      = req_vld_i;
`endif

   always_comb begin : pick
      int               v_idx;
      logic [SRC_W-1:0] v_sel;
      // NOTE: every combinational output gets a default first so no latch is inferred.
      v_idx   = 0;
      v_sel   = '0;
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
         v_sel = SRC_W'(v_idx);
         if (!w_found && w_cand[v_sel]) begin
            w_found = 1'b1;
            w_win   = v_sel;
         end
      end
   end

   assign w_xfer = w_allow && w_found;

   always_comb begin : route
      w_grant = '0;
      w_tag   = '0;
      w_data  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (SRC_W'(k) == w_win) begin
            w_grant[k] = w_xfer;
            w_tag      = req_tag_i[k*TAG_W +: TAG_W];
            w_data     = req_data_i[k*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_nxt = (w_win == SRC_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
   assign req_rdy_o = w_grant;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_tag  <= '0;
         r_data <= '0;
         r_src  <= '0;
         r_ptr  <= '0;
      end else if (flush) begin
         r_vld <= 1'b0;
      end else if (w_xfer) begin
         r_vld  <= 1'b1;
         r_tag  <= w_tag;
         r_data <= w_data;
         r_src  <= w_win;
         r_ptr  <= w_ptr_nxt;
      end else if (cdb_rdy_i) begin
         r_vld <= 1'b0;
      end
   end

   assign cdb_vld_o  = r_vld;
   assign cdb_tag_o  = r_tag;
   assign cdb_data_o = r_data;
   assign cdb_src_o  = r_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a driver predicts grants and queues expected CDB words,
// a separate monitor compares the broadcast port against the queue every cycle.
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TW = 4;
   localparam int SW = 2;

   typedef struct packed {
      logic [TW-1:0] tag;
      logic [W-1:0]  data;
      logic [SW-1:0] src;
   } word_t;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [N-1:0]  req_vld_i;
   logic [N*TW-1:0] req_tag_i;
   logic [N*W-1:0]  req_data_i;
   logic [N-1:0]  req_br_i;
   logic [N-1:0]  req_rdy_o;
   logic          cdb_rdy_i;
   logic          cdb_vld_o;
   logic [TW-1:0] cdb_tag_o;
   logic [W-1:0]  cdb_data_o;
   logic [SW-1:0] cdb_src_o;

   cdb_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_vld_i  (req_vld_i),
      .req_tag_i  (req_tag_i),
      .req_data_i (req_data_i),
      .req_br_i   (req_br_i),
      .req_rdy_o  (req_rdy_o),
      .cdb_rdy_i  (cdb_rdy_i),
      .cdb_vld_o  (cdb_vld_o),
      .cdb_tag_o  (cdb_tag_o),
      .cdb_data_o (cdb_data_o),
      .cdb_src_o  (cdb_src_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   word_t         sb[$];
   int            errors = 0;
   int            checks = 0;
   int            m_ptr  = 0;
   bit            mon_en = 1'b0;
   logic [TW-1:0] s_tag[N];
   logic [W-1:0]  s_data[N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Winner = valid requester at the smallest forward distance from the pointer.
   function automatic int model_winner(input logic [N-1:0] vld, input logic [N-1:0] br);
      logic [N-1:0] pool;
      int best;
      int best_d;
      pool = vld;
`ifdef OOPS_CDB_BRANCH_PRIO_EN
      if ((vld & br) != '0) pool = vld & br;
`else
      if (br === 'x) pool = vld;
`endif
      best   = -1;
      best_d = N;
      for (int i = 0; i < N; i++) begin
         if (pool[i] && ((i - m_ptr + N) % N) < best_d) begin
            best_d = (i - m_ptr + N) % N;
            best   = i;
         end
      end
      return best;
   endfunction

   task automatic cycle(input logic r, input logic f, input logic [N-1:0] vld,
                        input logic [N-1:0] br, input logic crdy);
      int           win;
      logic [N-1:0] exp_g;
      word_t        w;
      @(negedge clk);
      rst       = r;
      flush     = f;
      req_vld_i = vld;
      req_br_i  = br;
      cdb_rdy_i = crdy;
      for (int i = 0; i < N; i++) begin
         req_tag_i[i*TW +: TW] = s_tag[i];
         req_data_i[i*W +: W]  = s_data[i];
      end
      #1;
      win = -1;
      if ((sb.size() == 0 || crdy) && !f && !r) win = model_winner(vld, br);
      exp_g = '0;
      if (win >= 0) exp_g[win] = 1'b1;
      check("grant", 64'(req_rdy_o), 64'(exp_g));
      @(posedge clk);
      if (r) begin
         sb.delete();
         m_ptr = 0;
      end else if (f) begin
         sb.delete();
      end else if (win >= 0) begin
         w.tag  = s_tag[win];
         w.data = s_data[win];
         w.src  = SW'(win);
         sb.push_back(w);
         m_ptr = (win + 1) % N;
      end
   endtask

   // Monitor: just before each rising edge, compare the CDB port and retire consumed words.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (mon_en) begin
            check("cdb_vld", 64'(cdb_vld_o), 64'(sb.size() != 0));
            if (cdb_vld_o && sb.size() != 0)
               check("cdb_word", 64'({cdb_tag_o, cdb_data_o, cdb_src_o}), 64'(sb[0]));
            if (sb.size() != 0 && cdb_rdy_i && !flush && !rst) void'(sb.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; req_vld_i = '0; req_br_i = '0; cdb_rdy_i = 1'b0;
      req_tag_i = '0; req_data_i = '0;
      for (int i = 0; i < N; i++) begin
         s_tag[i]  = TW'(i + 1);
         s_data[i] = 32'hA000_0000 + i;
      end

      // Idle after reset.
      cycle(1, 0, 4'b0000, 4'b0000, 1);
      #1 check("reset_outputs", 64'({cdb_vld_o, cdb_tag_o, cdb_data_o, cdb_src_o}), 64'(0));
      mon_en = 1'b1;
      repeat (3) cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Fairness: all valid, grants rotate 0,1,2,3,0.
      repeat (5) cycle(0, 0, 4'b1111, 4'b0000, 1);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Backpressure with a held DEADBEEF word.
      s_data[0] = 32'hDEAD_BEEF;
      cycle(1, 0, 4'b1111, 4'b0000, 1);
      #1 check("reset_mid_stream", 64'({cdb_vld_o, cdb_tag_o, cdb_data_o, cdb_src_o}), 64'(0));
      cycle(0, 0, 4'b0001, 4'b0000, 1);
      repeat (3) cycle(0, 0, 4'b1111, 4'b0000, 0);
      cycle(0, 0, 4'b1111, 4'b0000, 1);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Flush while a word is held and requester 2 waits.
      cycle(0, 0, 4'b0100, 4'b0000, 0);
      cycle(0, 1, 4'b0100, 4'b0000, 0);
      cycle(0, 0, 4'b0100, 4'b0000, 0);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Branch priority from ptr=0.
      cycle(1, 0, 4'b0000, 4'b0000, 1);
      cycle(0, 0, 4'b1001, 4'b1000, 1);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Single streaming requester.
      repeat (6) cycle(0, 0, 4'b0010, 4'b0000, 1);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      // Randomized traffic with occasional flush and reset.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            s_tag[i]  = TW'($urandom);
            s_data[i] = $urandom;
         end
         cycle(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 5),
               N'($urandom), N'($urandom), logic'($urandom_range(0, 3) != 0));
      end
      cycle(0, 0, 4'b0000, 4'b0000, 1);
      cycle(0, 0, 4'b0000, 4'b0000, 1);

      @(negedge clk);
      #6;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of functional-unit result requesters (1..8).
REQ-002 SHALL have parameter WIDTH, default 32, result data width.
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, pipeline flush from branch mispredict.
REQ-007 SHALL have port req_vld_i, input, N_REQ, per-requester result valid.
REQ-008 SHALL have port req_tag_i, input, N_REQ*TAG_W, per-requester ROB tag, requester i at bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port req_data_i, input, N_REQ*WIDTH, per-requester result, requester i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port req_br_i, input, N_REQ, per-requester branch-result flag.
REQ-011 SHALL have port req_rdy_o, output, N_REQ, one-hot-or-zero grant; a transfer occurs when req_vld_i[i] and req_rdy_o[i] are both high.
REQ-012 SHALL have port cdb_rdy_i, input, 1, ROB/consumers accept the current CDB word.
REQ-013 SHALL have port cdb_vld_o, output, 1, CDB word valid.
REQ-014 SHALL have port cdb_tag_o, output, TAG_W, broadcast ROB tag.
REQ-015 SHALL have port cdb_data_o, output, WIDTH, broadcast result.
REQ-016 SHALL have port cdb_src_o, output, clog2(N_REQ) (minimum 1), index of the winning requester.

Function
REQ-017 SHALL hold the CDB word in a single output register; the register is free in a cycle when cdb_vld_o=0 or cdb_rdy_i=1.
REQ-018 SHALL drive req_rdy_o combinationally; at most one bit high, and only for a requester with req_vld_i high.
REQ-019 SHALL drive req_rdy_o to all-zero when the output register is not free, or when flush=1 or rst=1.
REQ-020 SHALL pick the winner round-robin: first valid requester found scanning upward from pointer ptr, wrapping from N_REQ-1 to 0.
REQ-021 SHALL set ptr to (winner+1) mod N_REQ on a transfer and leave ptr unchanged otherwise.
REQ-022 SHALL load the transferred tag, data and index into the output register, with cdb_vld_o=1 in the cycle after the grant (latency 1).
REQ-023 SHALL clear cdb_vld_o on the next edge when the word is consumed (cdb_vld_o=1, cdb_rdy_i=1) and no transfer occurs in the same cycle.
REQ-024 SHALL hold cdb_tag_o, cdb_data_o and cdb_src_o stable while cdb_vld_o=1 and cdb_rdy_i=0.
REQ-025 SHALL sustain one transfer per cycle when cdb_rdy_i is held high, with no bubbles.
REQ-026 SHALL, on flush=1, clear cdb_vld_o on the next edge, grant nothing in that cycle, and leave ptr unchanged.
REQ-027 SHALL guarantee that a continuously valid requester is granted within N_REQ transfers (macro undefined).
REQ-028 SHALL, with N_REQ=1, keep ptr at 0 and grant requester 0 whenever the output register is free.

Reset
REQ-029 SHALL, on a rising edge with rst=1, set cdb_vld_o=0, cdb_tag_o=0, cdb_data_o=0, cdb_src_o=0 and ptr=0.
REQ-030 SHALL give rst priority over flush and over any transfer, including a reset asserted mid-stream.
REQ-031 SHALL hold req_rdy_o all-zero during every cycle in which rst=1.

Configuration
REQ-032 SHALL, when macro OOPS_CDB_BRANCH_PRIO_EN is defined, grant requesters with req_br_i=1 ahead of all others; round-robin from ptr applies among branch requesters only, and among non-branch requesters only when no branch requester is valid.
REQ-033 SHALL, when OOPS_CDB_BRANCH_PRIO_EN is undefined, ignore req_br_i entirely.

Verification
REQ-034 SHALL cover idle after reset: rst 1 cycle, then all req_vld_i=0 -> cdb_vld_o=0, req_rdy_o=0000.
REQ-035 SHALL cover fairness: all four valid, tags 1,2,3,4, cdb_rdy_i=1 -> grants 0,1,2,3,0 on consecutive cycles; cdb_tag_o 1,2,3,4,1 one cycle later.
REQ-036 SHALL cover backpressure: cdb_vld_o=1, data 0xDEADBEEF, cdb_rdy_i=0 for 3 cycles -> req_rdy_o=0000 and outputs stable; the next grant follows cdb_rdy_i=1.
REQ-037 SHALL cover flush: cdb_vld_o=1, requester 2 valid, flush=1 -> no grant that cycle, cdb_vld_o=0 next cycle, ptr unchanged, requester 2 granted the cycle after.
REQ-038 SHALL cover branch priority: ptr=0, requester 0 non-branch and requester 3 branch both valid -> requester 3 granted with OOPS_CDB_BRANCH_PRIO_EN defined, requester 0 without it.
REQ-039 SHALL cover a single streaming requester: requester 1 continuously valid, cdb_rdy_i=1 -> granted every cycle, cdb_vld_o steady 1, cdb_src_o=1.
